// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, NOP word, jon encodings and fetch-stage state enum
package cpu_pkg;

  localparam logic [5:0] OP_BEQ  = 6'd32;
  localparam logic [5:0] OP_BNE  = 6'd33;
  localparam logic [5:0] OP_BLT  = 6'd34;
  localparam logic [5:0] OP_BLE  = 6'd35;
  localparam logic [5:0] OP_J    = 6'd40;
  localparam logic [5:0] OP_JR   = 6'd42;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [31:0] NOP_WORD = 32'h0;

  localparam logic [1:0] JON_NONE   = 2'b00;
  localparam logic [1:0] JON_JUMP   = 2'b01;
  localparam logic [1:0] JON_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_dec.sv
// rtl/ifetch_dec.sv - combinational instruction classifier shared by fetch and later stages
module ifetch_dec
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  jon,
  output logic [25:0] addr,
  output logic [5:0]  op,
  output logic [31:0] imm,
  output logic        is_halt
);

  always_comb begin
    op      = instr[31:26];
    addr    = instr[25:0];
    imm     = {{16{instr[15]}}, instr[15:0]};
    is_halt = (instr[31:26] == OP_HALT);
    jon     = JON_NONE;
    case (instr[31:26])
      OP_J:                                    jon = JON_JUMP;
      OP_BEQ, OP_BNE, OP_BLT, OP_BLE, OP_JR:   jon = JON_BRANCH;
      default:                                 jon = JON_NONE;
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - fetch/decode register with control-transfer squash and sticky halt
// Optional bubble counter port bubble_cnt enabled by IFETCH_PERF_EN.
module ifetch
  import cpu_pkg::*;
#(
  parameter int unsigned SQ_JUMP   = 1,
  parameter int unsigned SQ_BRANCH = 3
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] pc_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic [5:0]  op_d,
  output logic [31:0] imm_dpl_d,
  output logic [25:0] addr_d,
  output logic [1:0]  jon_d,
  output logic        halt
`ifdef IFETCH_PERF_EN
  ,output logic [31:0] bubble_cnt
`endif
);

  generate
    if (SQ_JUMP > 3 || SQ_BRANCH > 3) begin : g_sq_range_check
      $error("ifetch: SQ_JUMP and SQ_BRANCH must fit the 2-bit squash counter");
    end
  endgenerate

  localparam logic [1:0] SQ_JUMP_L   = SQ_JUMP[1:0];
  localparam logic [1:0] SQ_BRANCH_L = SQ_BRANCH[1:0];

  ifetch_state_e state_q, state_d;
  logic [1:0]  sq_cnt_q, sq_cnt_d;
  logic [31:0] dec_ir_q, dec_ir_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        dec_valid_q, dec_valid_d;
  logic        halt_q, halt_d;
  logic        load_bubble;
  logic [1:0]  dec_jon;
  logic        dec_is_halt;

  ifetch_dec u_dec (
    .instr   (dec_ir_q),
    .jon     (dec_jon),
    .addr    (addr_d),
    .op      (op_d),
    .imm     (imm_dpl_d),
    .is_halt (dec_is_halt)
  );

  assign imem_addr = pc_in;
  assign ir_d      = dec_ir_q;
  assign pc_d      = dec_pc_q;
  assign valid_d   = dec_valid_q;
  assign halt      = halt_q;
  assign jon_d     = dec_valid_q ? dec_jon : JON_NONE;

  // The edge that leaves RUN on a transfer already loads the first bubble.
  always_comb begin
    state_d     = state_q;
    sq_cnt_d    = sq_cnt_q;
    dec_ir_d    = imem_rdata;
    dec_pc_d    = pc_in;
    dec_valid_d = 1'b1;
    halt_d      = halt_q;
    load_bubble = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dec_valid_q && dec_jon == JON_JUMP) begin
          state_d     = ST_SQUASH;
          sq_cnt_d    = SQ_JUMP_L;
          load_bubble = 1'b1;
        end else if (dec_valid_q && dec_jon == JON_BRANCH) begin
          state_d     = ST_SQUASH;
          sq_cnt_d    = SQ_BRANCH_L;
          load_bubble = 1'b1;
        end else if (dec_valid_q && dec_is_halt) begin
          state_d     = ST_HALT;
          halt_d      = 1'b1;
          dec_ir_d    = NOP_WORD;
          dec_pc_d    = dec_pc_q;
          dec_valid_d = 1'b0;
        end
      end
      ST_SQUASH: begin
        if (sq_cnt_q <= 2'd1) begin
          state_d  = ST_RUN;
          sq_cnt_d = 2'd0;
        end else begin
          sq_cnt_d    = sq_cnt_q - 2'd1;
          load_bubble = 1'b1;
        end
      end
      ST_HALT: begin
        dec_ir_d    = NOP_WORD;
        dec_pc_d    = dec_pc_q;
        dec_valid_d = 1'b0;
        halt_d      = 1'b1;
      end
      default: begin
        state_d  = ST_RUN;
        sq_cnt_d = 2'd0;
      end
    endcase
    if (load_bubble) begin
      dec_ir_d    = NOP_WORD;
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q     <= ST_RUN;
      sq_cnt_q    <= 2'd0;
      dec_ir_q    <= NOP_WORD;
      dec_pc_q    <= 32'h0;
      dec_valid_q <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      dec_ir_q    <= dec_ir_d;
      dec_pc_q    <= dec_pc_d;
      dec_valid_q <= dec_valid_d;
      halt_q      <= halt_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // HALT never loads a bubble, so the count freezes there on its own.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && bubble_cnt_q != 32'hFFFF_FFFF) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      bubble_cnt_q <= 32'h0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch / decode-register stage that consumes the fetch address produced by the `pc` unit and produces the control-transfer signals `pc` consumes (`jon_d`, `addr_d`). Each cycle it presents the current PC to instruction memory and registers the returned word into the decode stage. It classifies control-transfer opcodes and squashes wrong-path instructions fetched in the jump/branch shadow. On the halt opcode it stops issuing.

## Interface
- `SQ_JUMP`, 1: bubbles inserted after a decoded jump (op 40).
- `SQ_BRANCH`, 3: bubbles inserted after a decoded branch or `jr` (op 32–35, 42).
- `clk` in 1: single clock, rising edge.
- `rstd` in 1: reset, asynchronous, active-low.
- `pc_in` in 32: word-address PC from `pc`.
- `imem_addr` out 32: equals `pc_in`, combinational.
- `imem_rdata` in 32: instruction word; asynchronous read, valid in the same cycle.
- `ir_d` out 32: registered instruction; NOP (32'h0) when squashed.
- `pc_d` out 32: PC of `ir_d`.
- `valid_d` out 1: `ir_d` is a real, non-squashed instruction.
- `op_d` out 6: `ir_d[31:26]`.
- `imm_dpl_d` out 32: `ir_d[15:0]` sign-extended.
- `addr_d` out 26: `ir_d[25:0]`; byte address, which `pc` shifts right by 2.
- `jon_d` out 2: 2'b01 = jump, 2'b10 = branch/jr, 2'b00 = otherwise. Only asserted when `valid_d` = 1.
- `halt` out 1: sticky; set once op 63 has been decoded.
- `bubble_cnt` out 32: present only under `IFETCH_PERF_EN`.

## Operation
- States:
  - RUN: capture `imem_rdata` → `ir_d`, `pc_in` → `pc_d`, set `valid_d` = 1.
  - SQUASH: load NOP, set `valid_d` = 0, decrement `sq_cnt`.
  - HALT: hold NOP with `valid_d` = 0, and hold `halt` = 1.
- Transitions, evaluated on the registered `ir_d` at each edge:
  - RUN with `valid_d` && op 40 → SQUASH, `sq_cnt` = `SQ_JUMP`.
  - RUN with `valid_d` && op ∈ {32,33,34,35,42} → SQUASH, `sq_cnt` = `SQ_BRANCH`.
  - RUN with `valid_d` && op 63 → HALT.
  - SQUASH with `sq_cnt` = 1 → RUN, which captures the target instruction on that edge.
- The word captured on the transition edge itself is already squashed. That edge counts as bubble 1.
- Squashed NOPs never decode as control transfer, so nested jumps cannot occur.
- HALT is left only by reset.
- `sq_cnt` is 2 bits wide. Parameter values above 3 are illegal and caught by elaboration check.

## Timing
- Reset (async, immediate) values:
  - `ir_d` = 0, `pc_d` = 0, `valid_d` = 0.
  - `jon_d` = 00, `addr_d` = 0, `op_d` = 0, `imm_dpl_d` = 0.
  - `halt` = 0, `bubble_cnt` = 0, state = RUN, `sq_cnt` = 0.
- Fetch-to-decode latency: 1 cycle. Word at `pc_in` in cycle n appears on `ir_d` in cycle n+1.
- `jon_d`, `addr_d`, `op_d`, `imm_dpl_d` are combinational from `ir_d`. They are stable for the whole decode cycle.
- Jump at `pc_d` = P in cycle k:
  - Cycle k+1 holds a bubble (I(P+1) squashed).
  - Cycle k+2 holds I(target).
- Branch at P in cycle k:
  - Cycles k+1..k+3 hold bubbles (I(P+1..P+3)).
  - Cycle k+4 holds I(npc).
  - This matches `pc`'s `jump_count` resolving on its second edge after `jon_d[1]`.
- Halt decoded in cycle k: `halt` = 1 and `valid_d` = 0 from cycle k+1.
- Reset mid-squash or during HALT discards all state. The first capture after deassertion is in RUN.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Port `bubble_cnt` exists.
  - It increments by 1 on every edge that loads a squash bubble.
  - It saturates at 32'hFFFFFFFF and freezes in HALT.
- `IFETCH_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `cpu_pkg` holds:
  - opcode constants `OP_BEQ`=32, `OP_BNE`=33, `OP_BLT`=34, `OP_BLE`=35, `OP_J`=40, `OP_JR`=42, `OP_HALT`=63;
  - `NOP_WORD` = 32'h0;
  - `jon_d` encodings `JON_NONE`, `JON_JUMP`, `JON_BRANCH`;
  - the state enum.
- One sub-module, `ifetch_dec`, is natural:
  - combinational classification of an instruction into `jon`, `addr`, `op`, `imm`, `is_halt`;
  - reusable by later stages.

## Test plan
- Reset, then straight-line words 0x04000001..0x04000004 at PC 0..3 → `ir_d` follows one cycle late; `valid_d` = 1; `jon_d` = 00.
- Op 40 with `addr_d` = 0x000040 at P = 5 → `jon_d` = 01 for one cycle; exactly one bubble (`valid_d` = 0); then the word at PC 0x10 appears.
- Op 32 at P = 8 → `jon_d` = 10; three bubbles; the next valid `pc_d` equals the resolved npc (9 + imm>>2, or 9).
- Op 63 at P = 12 → `halt` = 1 from the next cycle; `valid_d` stays 0 for 20 cycles regardless of `imem_rdata`.
- `rstd` low during the second branch bubble → immediate zeroed outputs; after release the first word at PC 0 is valid with no residual bubbles.
- With `IFETCH_PERF_EN`: one jump plus two branches → `bubble_cnt` = 7.
